// File: rtl/camo_pkg.sv
// Shared definitions for the camouflage key loader: cell select codes and loader states.
package camo_pkg;

  // Cell codes as {D_odd, D_even}
  localparam logic [1:0] CAMO_BUF = 2'b00;
  localparam logic [1:0] CAMO_INV = 2'b10;
  localparam logic [1:0] CAMO_C1  = 2'b01;
  localparam logic [1:0] CAMO_C0  = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} ldr_state_t;

endpackage

// File: rtl/camo_key_loader_if.sv
// Serial key-bit handshake between the configuration port and the key loader.
interface camo_key_loader_if;
  logic sdata;
  logic svalid;
  logic sready;

  modport master (output sdata, output svalid, input sready);
  modport slave  (input sdata, input svalid, output sready);
endinterface

// File: rtl/camo_key_shreg.sv
// LSB-first key shift register with running parity and accepted-bit counter.
module camo_key_shreg #(
  parameter int unsigned KEY_W = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sdata,
  output logic [KEY_W-1:0] shreg,
  output logic [CNT_W-1:0] cnt,
  output logic             acc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
    end else if (shift_en) begin
      shreg <= {sdata, shreg[KEY_W-1:1]};
      cnt   <= cnt + 1'b1;
      acc   <= acc ^ sdata;
    end
  end

endmodule

// File: rtl/camo_key_loader.sv
// Serial key loader: shifts in KEY_W select bits plus an even-parity trailer and
// applies them atomically to the camouflage select lines, with optional lock.
module camo_key_loader
  import camo_pkg::*;
#(
  parameter  int unsigned NUM_CELLS = 2,
  localparam int unsigned KEY_W     = 2 * NUM_CELLS,
  localparam int unsigned CNT_W     = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             lock_req_i,
  camo_key_loader_if.slave sif,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             locked_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

  ldr_state_t       state_q, state_d;
  logic [KEY_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             accept;
  logic             clear, shift_en, commit;
  logic             done_d, err_d;
  logic             lock_pend;

  assign sif.sready = (state_q == SHIFT) || (state_q == PARITY);
  assign accept     = sif.svalid & sif.sready;
  assign busy_o     = (state_q != IDLE);

  camo_key_shreg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (shift_en),
    .sdata    (sif.sdata),
    .shreg    (shreg),
    .cnt      (cnt),
    .acc      (acc)
  );

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (locked_o) begin
            err_d = 1'b1;
          end else begin
            clear   = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          shift_en = 1'b1;
          if (cnt == CNT_LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (accept) begin
          if ((acc ^ sif.sdata) == 1'b0) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done_o is registered from the COMMIT cycle so it lines up with the new key_o
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_o       <= {NUM_CELLS{CAMO_BUF}};
      key_valid_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      locked_o    <= 1'b0;
      lock_pend   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= done_d;
      err_o   <= err_d;
      if (clear) lock_pend <= lock_req_i;
      if (commit) begin
        key_o       <= shreg;
        key_valid_o <= 1'b1;
        locked_o    <= lock_pend;
      end
    end
  end

endmodule
